cnt100_seq_ctrl: RTL and testbench

//  Sequencer for the two-digit BCD counter CNT100 (ports LOAD, EN, UP, IN[7:0], Q[7:0]).

---
 rtl/cnt100_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_cnt100_seq_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cnt100_seq_ctrl.sv
// Sequencer for a CNT100 BCD counter: loads a preset and steps toward a target at a TICK_DIV rate, then pulses DONE.
// DONE arrives 2+N*TICK_DIV clocks after acceptance; CMD_READY is high only in IDLE, and PAUSE freezes stepping.
module cnt100_seq_ctrl #(
    parameter int TICK_DIV = 1,
    parameter int PW       = 8
) (
    input  logic       CLK,
    input  logic       RESET_B,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic [7:0] CMD_PRESET,
    input  logic [7:0] CMD_TARGET,
    input  logic       CMD_UP,
    input  logic       PAUSE,
    input  logic       ABORT,
    input  logic [7:0] Q,
    output logic       LOAD,
    output logic       EN,
    output logic       UP,
    output logic [7:0] IN,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [PW-1:0] LP_TICK_MAX = PW'(TICK_DIV - 1);

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [7:0]    r_preset;
    logic [7:0]    r_target;
    logic          r_up;
    logic          r_err;
    logic          r_load;
    logic          r_run;
    logic          r_done;
    logic          r_busy;
    logic          r_ready;

    logic w_accept;
    logic w_cmd_ok;
    logic w_tick;
    logic w_at_target;

    function automatic logic is_bcd(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    assign w_accept    = CMD_VALID & r_ready;
    assign w_cmd_ok    = is_bcd(CMD_PRESET) & is_bcd(CMD_TARGET);
    assign w_tick      = (r_presc == LP_TICK_MAX);
    // Live Q is compared so the final step is never followed by an overshoot.
    assign w_at_target = (Q == r_target);

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            r_state  <= S_IDLE;
            r_presc  <= '0;
            r_preset <= 8'h00;
            r_target <= 8'h00;
            r_up     <= 1'b0;
            r_err    <= 1'b0;
            r_load   <= 1'b0;
            r_run    <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_cmd_ok) begin
                            r_preset <= CMD_PRESET;
                            r_target <= CMD_TARGET;
                            r_up     <= CMD_UP;
                            r_state  <= S_LOAD;
                            r_load   <= 1'b1;
                            r_busy   <= 1'b1;
                            r_ready  <= 1'b0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    r_load  <= 1'b0;
                    r_presc <= '0;
                    if (ABORT) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end else begin
                        r_state <= S_RUN;
                        r_run   <= 1'b1;
                    end
                end
                S_RUN: begin
                    // ABORT takes priority over reaching the target in the same cycle.
                    if (ABORT) begin
                        r_state <= S_IDLE;
                        r_run   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end else if (w_at_target) begin
                        r_state <= S_DONE;
                        r_run   <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (!PAUSE) begin
                        r_presc <= w_tick ? '0 : r_presc + PW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_load  <= 1'b0;
                    r_run   <= 1'b0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign LOAD      = r_load & ~ABORT;
    assign EN        = r_run & w_tick & ~PAUSE & ~ABORT & ~w_at_target;
    assign UP        = r_up;
    assign IN        = r_preset;
    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign ERR       = r_err;
    assign CMD_READY = r_ready;

endmodule

// File: tb/tb_cnt100_seq_ctrl.sv
// Bench for cnt100_seq_ctrl: two instances (TICK_DIV 1 and 3) each driving a behavioural CNT100,
// checked against step counts and DONE timing computed from preset/target arithmetic.
module tb_cnt100_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n      [2];
    logic       cmd_valid  [2];
    logic       cmd_ready  [2];
    logic [7:0] cmd_preset [2];
    logic [7:0] cmd_target [2];
    logic       cmd_up     [2];
    logic       pause      [2];
    logic       abort_i    [2];
    logic [7:0] q          [2] = '{8'h00, 8'h00};
    logic       load       [2];
    logic       en         [2];
    logic       up_o       [2];
    logic [7:0] in_o       [2];
    logic       busy       [2];
    logic       done       [2];
    logic       err        [2];

    int n_vec = 0;
    int n_err = 0;

    cnt100_seq_ctrl #(.TICK_DIV(1), .PW(8)) u_dut0 (
        .CLK(clk), .RESET_B(rst_n[0]), .CMD_VALID(cmd_valid[0]), .CMD_READY(cmd_ready[0]),
        .CMD_PRESET(cmd_preset[0]), .CMD_TARGET(cmd_target[0]), .CMD_UP(cmd_up[0]),
        .PAUSE(pause[0]), .ABORT(abort_i[0]), .Q(q[0]), .LOAD(load[0]), .EN(en[0]),
        .UP(up_o[0]), .IN(in_o[0]), .BUSY(busy[0]), .DONE(done[0]), .ERR(err[0])
    );

    cnt100_seq_ctrl #(.TICK_DIV(3), .PW(8)) u_dut1 (
        .CLK(clk), .RESET_B(rst_n[1]), .CMD_VALID(cmd_valid[1]), .CMD_READY(cmd_ready[1]),
        .CMD_PRESET(cmd_preset[1]), .CMD_TARGET(cmd_target[1]), .CMD_UP(cmd_up[1]),
        .PAUSE(pause[1]), .ABORT(abort_i[1]), .Q(q[1]), .LOAD(load[1]), .EN(en[1]),
        .UP(up_o[1]), .IN(in_o[1]), .BUSY(busy[1]), .DONE(done[1]), .ERR(err[1])
    );

    function automatic int b2i(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] i2b(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Behavioural CNT100: load beats enable, BCD wrap modulo 100.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (load[g])
                q[g] <= in_o[g];
            else if (en[g])
                q[g] <= i2b((b2i(q[g]) + (up_o[g] ? 1 : 99)) % 100);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input int k, input logic [7:0] p, input logic [7:0] t, input logic u,
                           input int pa, input int pl, input int ab,
                           input logic hold, input logic [7:0] hp, input logic [7:0] ht, input logic hu);
        int td, n, steps, c;
        int load_cnt, en_cnt, done_c, end_c, bad;
        int exp_done, exp_end, exp_en, exp_load;
        logic [7:0] q_before, exp_q;
        td = (k == 1) ? 3 : 1;
        n  = u ? (b2i(t) - b2i(p) + 100) % 100 : (b2i(p) - b2i(t) + 100) % 100;
        q_before = q[k];
        load_cnt = 0; en_cnt = 0; done_c = -1; end_c = -1; bad = 0;
        cmd_preset[k] = p; cmd_target[k] = t; cmd_up[k] = u; cmd_valid[k] = 1'b1;
        #1;
        chk("ready_before_accept", 32'(cmd_ready[k]), 32'd1);
        tick();
        if (hold) begin
            cmd_preset[k] = hp; cmd_target[k] = ht; cmd_up[k] = hu;
        end else begin
            cmd_valid[k] = 1'b0;
        end
        for (c = 0; c < 500; c++) begin
            pause[k]   = (pl > 0) && (c >= pa) && (c < pa + pl);
            abort_i[k] = (c == ab);
            #1;
            if (load[k]) load_cnt++;
            if (en[k]) en_cnt++;
            if (done[k] && done_c < 0) done_c = c;
            if (busy[k] && (cmd_ready[k] || in_o[k] !== p || up_o[k] !== u)) bad++;
            if (!busy[k] && c >= 1) begin
                end_c = c;
                break;
            end
            tick();
        end
        pause[k] = 1'b0;
        abort_i[k] = 1'b0;
        if (ab < 0) begin
            exp_done = 2 + n * td + pl; exp_end = exp_done + 1;
            exp_en = n; exp_load = 1; exp_q = t;
        end else if (ab == 0) begin
            exp_done = -1; exp_end = 1; exp_en = 0; exp_load = 0; exp_q = q_before;
        end else begin
            steps = (ab - 1) / td;
            if (steps > n) steps = n;
            exp_done = -1; exp_end = ab + 1; exp_en = steps; exp_load = 1;
            exp_q = i2b((b2i(p) + (u ? steps : 100 - steps)) % 100);
        end
        chk("load_cycles", 32'(load_cnt), 32'(exp_load));
        chk("en_steps", 32'(en_cnt), 32'(exp_en));
        chk("done_cycle", 32'(done_c), 32'(exp_done));
        chk("idle_cycle", 32'(end_c), 32'(exp_end));
        chk("final_q", 32'(q[k]), 32'(exp_q));
        chk("busy_ctl_consistency", 32'(bad), 32'd0);
        chk("ready_after", 32'(cmd_ready[k]), 32'd1);
    endtask

    task automatic reject(input int k, input logic [7:0] p, input logic [7:0] t);
        logic [7:0] q_before;
        q_before = q[k];
        cmd_preset[k] = p; cmd_target[k] = t; cmd_up[k] = 1'b1; cmd_valid[k] = 1'b1;
        #1;
        chk("rej_ready", 32'(cmd_ready[k]), 32'd1);
        tick();
        cmd_valid[k] = 1'b0;
        #1;
        chk("rej_err_pulse", 32'(err[k]), 32'd1);
        chk("rej_busy", 32'(busy[k]), 32'd0);
        chk("rej_load", 32'(load[k]), 32'd0);
        tick();
        #1;
        chk("rej_err_clear", 32'(err[k]), 32'd0);
        chk("rej_busy_after", 32'(busy[k]), 32'd0);
        chk("rej_q_kept", 32'(q[k]), 32'(q_before));
    endtask

    task automatic random_cmds(input int k, input int count);
        int td, n, mode, pa, pl, ab;
        logic [7:0] p, t;
        logic u;
        td = (k == 1) ? 3 : 1;
        for (int i = 0; i < count; i++) begin
            p = i2b($urandom_range(0, 99));
            t = i2b($urandom_range(0, 99));
            u = 1'($urandom_range(0, 1));
            n = u ? (b2i(t) - b2i(p) + 100) % 100 : (b2i(p) - b2i(t) + 100) % 100;
            mode = $urandom_range(0, 3);
            pa = 0; pl = 0; ab = -1;
            if (mode == 1 && n > 0) begin
                pa = $urandom_range(1, n * td);
                pl = $urandom_range(1, 5);
            end else if (mode == 2) begin
                ab = $urandom_range(0, 1 + n * td);
            end
            if (mode == 3) begin
                t[3:0] = 4'($urandom_range(10, 15));
                reject(k, p, t);
            end else begin
                run_cmd(k, p, t, u, pa, pl, ab, 1'b0, 8'h00, 8'h00, 1'b0);
            end
        end
    endtask

    initial begin
        logic [7:0] q_snap;
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; cmd_valid[k] = 1'b0; cmd_preset[k] = 8'h00; cmd_target[k] = 8'h00;
            cmd_up[k] = 1'b0; pause[k] = 1'b0; abort_i[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready", 32'(cmd_ready[k]), 32'd1);
            chk("rst_busy", 32'(busy[k]), 32'd0);
            chk("rst_load_en", 32'({load[k], en[k], done[k], err[k], up_o[k]}), 32'd0);
            chk("rst_in", 32'(in_o[k]), 32'h00);
            rst_n[k] = 1'b1;
        end
        tick();

        run_cmd(0, 8'h95, 8'h05, 1'b1, 0, 0, -1, 1'b0, 8'h00, 8'h00, 1'b0);
        run_cmd(1, 8'h02, 8'h98, 1'b0, 0, 0, -1, 1'b0, 8'h00, 8'h00, 1'b0);
        run_cmd(0, 8'h10, 8'h30, 1'b1, 5, 5, -1, 1'b0, 8'h00, 8'h00, 1'b0);
        run_cmd(1, 8'h10, 8'h13, 1'b1, 4, 5, -1, 1'b0, 8'h00, 8'h00, 1'b0);
        run_cmd(0, 8'h42, 8'h42, 1'b1, 0, 0, -1, 1'b0, 8'h00, 8'h00, 1'b0);
        run_cmd(1, 8'h42, 8'h42, 1'b0, 0, 0, -1, 1'b0, 8'h00, 8'h00, 1'b0);
        reject(0, 8'h3A, 8'h10);
        reject(1, 8'h10, 8'hA1);
        run_cmd(0, 8'h20, 8'h40, 1'b1, 0, 0, 3, 1'b0, 8'h00, 8'h00, 1'b0);
        run_cmd(1, 8'h50, 8'h40, 1'b0, 0, 0, 7, 1'b0, 8'h00, 8'h00, 1'b0);
        run_cmd(0, 8'h11, 8'h77, 1'b1, 0, 0, 0, 1'b0, 8'h00, 8'h00, 1'b0);
        run_cmd(0, 8'h10, 8'h13, 1'b1, 0, 0, 4, 1'b0, 8'h00, 8'h00, 1'b0);
        run_cmd(0, 8'h00, 8'h03, 1'b1, 0, 0, -1, 1'b1, 8'h07, 8'h05, 1'b0);
        run_cmd(0, 8'h07, 8'h05, 1'b0, 0, 0, -1, 1'b0, 8'h00, 8'h00, 1'b0);

        // Reset in the middle of a run on instance 0.
        cmd_preset[0] = 8'h00; cmd_target[0] = 8'h50; cmd_up[0] = 1'b1; cmd_valid[0] = 1'b1;
        tick();
        cmd_valid[0] = 1'b0;
        repeat (4) tick();
        #1;
        chk("midrun_en", 32'(en[0]), 32'd1);
        q_snap = q[0];
        rst_n[0] = 1'b0;
        #1;
        chk("midrst_load_en_busy", 32'({load[0], en[0], busy[0]}), 32'd0);
        chk("midrst_ready", 32'(cmd_ready[0]), 32'd1);
        chk("midrst_in", 32'(in_o[0]), 32'h00);
        tick();
        #1;
        chk("midrst_q_kept", 32'(q[0]), 32'(q_snap));
        rst_n[0] = 1'b1;
        tick();

        random_cmds(0, 20);
        random_cmds(1, 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
